pipe_hazard_scoreboard: RTL and testbench

Parametrised successor to the fixed five-stage hazard, forwarding and stall control. It keeps a shift-register scoreboard of in-flight writers across NSTAGE post-decode stages (E=1 … W=NSTAGE). From Tuse/Tnew it computes the D-stage stall and the D- and E-stage forwarding selects. It adds a multi-cycle mult/div busy interlock and a whole-pipe flush for interrupts. It sits between the decode-stage A/T coder and the datapath forwarding muxes and pipe registers.

---
 rtl/pipe_hazard_scoreboard.sv | 155 +++++++++++++++
 tb/tb_pipe_hazard_scoreboard.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_scoreboard.sv
// Hazard/forwarding control: NSTAGE-deep writer scoreboard, Tuse/Tnew stall, D/E forwarding
// selects, mult/div interlock and flush. Define HAZ_PERF_EN to build the stalled-cycle counter.
module pipe_hazard_scoreboard #(
    parameter int unsigned NSTAGE = 3,
    parameter int unsigned TW     = 2,
    parameter int unsigned MD_LAT = 5,
    localparam int unsigned SELW  = $clog2(NSTAGE + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            d_valid,
    input  logic [4:0]      d_ra1,
    input  logic [4:0]      d_ra2,
    input  logic [TW-1:0]   d_tuse1,
    input  logic [TW-1:0]   d_tuse2,
    input  logic [4:0]      d_wa,
    input  logic [TW-1:0]   d_tnew,
    input  logic            d_md,
    input  logic            d_md_use,
    output logic            stall,
    output logic            pcen,
    output logic            den,
    output logic            eclr,
    output logic [SELW-1:0] fwd_d1,
    output logic [SELW-1:0] fwd_d2,
    output logic [SELW-1:0] fwd_e1,
    output logic [SELW-1:0] fwd_e2,
    output logic            md_busy,
    output logic [31:0]     stall_cnt
);

    localparam int unsigned MDW = $clog2(MD_LAT + 1);

    logic            r_valid [1:NSTAGE];
    logic [4:0]      r_wa    [1:NSTAGE];
    logic [TW-1:0]   r_tnew  [1:NSTAGE];
    logic [4:0]      r_ra1;
    logic [4:0]      r_ra2;
    logic [MDW-1:0]  r_md_cnt;

    logic [4:0]      w_dra    [2];
    logic [TW-1:0]   w_duse   [2];
    logic [4:0]      w_era    [2];
    logic [1:0]      w_found_d;
    logic [1:0]      w_found_e;
    logic [1:0]      w_dhaz;
    logic [SELW-1:0] w_fwd_d  [2];
    logic [SELW-1:0] w_fwd_e  [2];
    logic            w_md_busy;
    logic            w_stall;

    always_comb begin
        w_dra[0]  = d_ra1;
        w_dra[1]  = d_ra2;
        w_duse[0] = d_tuse1;
        w_duse[1] = d_tuse2;
        w_era[0]  = r_ra1;
        w_era[1]  = r_ra2;
    end

    // Youngest matching writer (lowest stage index) decides each operand.
    always_comb begin
        w_found_d = '0;
        w_found_e = '0;
        w_dhaz    = '0;
        for (int j = 0; j < 2; j++) begin
            w_fwd_d[j] = '0;
            w_fwd_e[j] = '0;
            for (int k = 1; k <= NSTAGE; k++) begin
                if (d_valid && !w_found_d[j] && r_valid[k] &&
                    (w_dra[j] != 5'd0) && (r_wa[k] == w_dra[j])) begin
                    w_found_d[j] = 1'b1;
                    if (r_tnew[k] > w_duse[j]) begin
                        w_dhaz[j] = 1'b1;
                    end else if (r_tnew[k] == '0) begin
                        w_fwd_d[j] = SELW'(k);
                    end
                end
                if ((k >= 2) && r_valid[1] && !w_found_e[j] && r_valid[k] &&
                    (w_era[j] != 5'd0) && (r_wa[k] == w_era[j])) begin
                    w_found_e[j] = 1'b1;
                    if (r_tnew[k] == '0) begin
                        w_fwd_e[j] = SELW'(k);
                    end
                end
            end
        end
    end

    assign w_md_busy = (r_md_cnt != '0);
    assign w_stall   = (|w_dhaz) | (d_valid & (d_md | d_md_use) & w_md_busy);

    // Scoreboard advance; flush empties the pipe but the current outputs still stand.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 1; k <= NSTAGE; k++) begin
                r_valid[k] <= 1'b0;
                r_wa[k]    <= '0;
                r_tnew[k]  <= '0;
            end
            r_ra1    <= '0;
            r_ra2    <= '0;
            r_md_cnt <= '0;
        end else if (flush) begin
            for (int k = 1; k <= NSTAGE; k++) begin
                r_valid[k] <= 1'b0;
            end
            r_md_cnt <= '0;
        end else begin
            r_valid[1] <= d_valid & ~w_stall;
            r_wa[1]    <= d_wa;
            r_tnew[1]  <= d_tnew;
            r_ra1      <= d_ra1;
            r_ra2      <= d_ra2;
            for (int k = 2; k <= NSTAGE; k++) begin
                r_valid[k] <= r_valid[k-1];
                r_wa[k]    <= r_wa[k-1];
                r_tnew[k]  <= (r_tnew[k-1] == '0) ? '0 : r_tnew[k-1] - TW'(1);
            end
            if (d_valid && d_md && !w_stall) begin
                r_md_cnt <= MDW'(MD_LAT);
            end else if (w_md_busy) begin
                r_md_cnt <= r_md_cnt - MDW'(1);
            end
        end
    end

`ifdef HAZ_PERF_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = 32'd0;
`endif

    assign stall   = w_stall;
    assign pcen    = ~w_stall;
    assign den     = ~w_stall;
    assign eclr    = w_stall;
    assign fwd_d1  = w_fwd_d[0];
    assign fwd_d2  = w_fwd_d[1];
    assign fwd_e1  = w_fwd_e[0];
    assign fwd_e2  = w_fwd_e[1];
    assign md_busy = w_md_busy;

endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// Directed bench for pipe_hazard_scoreboard with hand-computed expectations (NSTAGE=3, TW=2, MD_LAT=5).
module tb_pipe_hazard_scoreboard;

    localparam int unsigned NSTAGE = 3;
    localparam int unsigned TW     = 2;
    localparam int unsigned MD_LAT = 5;
    localparam int unsigned SELW   = $clog2(NSTAGE + 1);

    logic            clk;
    logic            rst;
    logic            flush;
    logic            d_valid;
    logic [4:0]      d_ra1;
    logic [4:0]      d_ra2;
    logic [TW-1:0]   d_tuse1;
    logic [TW-1:0]   d_tuse2;
    logic [4:0]      d_wa;
    logic [TW-1:0]   d_tnew;
    logic            d_md;
    logic            d_md_use;
    logic            stall;
    logic            pcen;
    logic            den;
    logic            eclr;
    logic [SELW-1:0] fwd_d1;
    logic [SELW-1:0] fwd_d2;
    logic [SELW-1:0] fwd_e1;
    logic [SELW-1:0] fwd_e2;
    logic            md_busy;
    logic [31:0]     stall_cnt;

    int n_chk;
    int n_fail;

    pipe_hazard_scoreboard #(
        .NSTAGE (NSTAGE),
        .TW     (TW),
        .MD_LAT (MD_LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .d_valid   (d_valid),
        .d_ra1     (d_ra1),
        .d_ra2     (d_ra2),
        .d_tuse1   (d_tuse1),
        .d_tuse2   (d_tuse2),
        .d_wa      (d_wa),
        .d_tnew    (d_tnew),
        .d_md      (d_md),
        .d_md_use  (d_md_use),
        .stall     (stall),
        .pcen      (pcen),
        .den       (den),
        .eclr      (eclr),
        .fwd_d1    (fwd_d1),
        .fwd_d2    (fwd_d2),
        .fwd_e1    (fwd_e1),
        .fwd_e2    (fwd_e2),
        .md_busy   (md_busy),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] ra1, input logic [TW-1:0] tu1,
                         input logic [4:0] ra2, input logic [TW-1:0] tu2,
                         input logic [4:0] wa, input logic [TW-1:0] tnew,
                         input logic md, input logic mu);
        d_valid  = v;
        d_ra1    = ra1;
        d_tuse1  = tu1;
        d_ra2    = ra2;
        d_tuse2  = tu2;
        d_wa     = wa;
        d_tnew   = tnew;
        d_md     = md;
        d_md_use = mu;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic nop();
        drive(1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            nop();
        end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        flush  = 1'b0;
        rst    = 1'b0;
        // Arbitrary valid instruction held across reset; wa=0 so it is harmless afterwards.
        drive(1'b1, 5'd7, 2'd1, 5'd9, 2'd2, 5'd0, 2'd3, 1'b0, 1'b1);
        @(posedge clk);
        @(posedge clk);
        step();
        rst = 1'b1;
        #1;
        chk("rst_stall",   32'(stall),   32'd0);
        chk("rst_pcen",    32'(pcen),    32'd1);
        chk("rst_den",     32'(den),     32'd1);
        chk("rst_eclr",    32'(eclr),    32'd0);
        chk("rst_fwd_d1",  32'(fwd_d1),  32'd0);
        chk("rst_fwd_d2",  32'(fwd_d2),  32'd0);
        chk("rst_fwd_e1",  32'(fwd_e1),  32'd0);
        chk("rst_fwd_e2",  32'(fwd_e2),  32'd0);
        chk("rst_md_busy", 32'(md_busy), 32'd0);
        chk("rst_scnt",    stall_cnt,    32'd0);

        // Load-use: lw $8 (tnew=2) then add reading $8 at tuse=1.
        step(); drive(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd8, 2'd2, 1'b0, 1'b0); #1;
        chk("lu_lw_stall", 32'(stall), 32'd0);
        step(); drive(1'b1, 5'd8, 2'd1, 5'd0, 2'd3, 5'd9, 2'd1, 1'b0, 1'b0); #1;
        chk("lu_stall", 32'(stall), 32'd1);
        chk("lu_eclr",  32'(eclr),  32'd1);
        chk("lu_pcen",  32'(pcen),  32'd0);
        chk("lu_den",   32'(den),   32'd0);
        step(); #1;
        chk("lu_release",  32'(stall),  32'd0);
        chk("lu_fwd_d1",   32'(fwd_d1), 32'd0);
        step(); nop(); #1;
        chk("lu_fwd_e1", 32'(fwd_e1), 32'd3);
        chk("lu_fwd_e2", 32'(fwd_e2), 32'd0);
        idle(3);

        // Branch: add $3 (tnew=1) then beq reading $3 on both ports at tuse=0.
        step(); drive(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd3, 2'd1, 1'b0, 1'b0); #1;
        chk("br_add_stall", 32'(stall), 32'd0);
        step(); drive(1'b1, 5'd3, 2'd0, 5'd3, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0); #1;
        chk("br_stall", 32'(stall), 32'd1);
        step(); #1;
        chk("br_release", 32'(stall),  32'd0);
        chk("br_fwd_d1",  32'(fwd_d1), 32'd2);
        chk("br_fwd_d2",  32'(fwd_d2), 32'd2);
        step(); nop(); #1;
        chk("br_fwd_e1", 32'(fwd_e1), 32'd3);
        chk("br_fwd_e2", 32'(fwd_e2), 32'd3);
        idle(3);

        // Youngest wins; a pending writer of $0 must never match.
        step(); drive(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd3, 1'b0, 1'b0);
        step(); drive(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd5, 2'd0, 1'b0, 1'b0);
        step(); drive(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd5, 2'd0, 1'b0, 1'b0);
        step(); drive(1'b1, 5'd0, 2'd0, 5'd5, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0); #1;
        chk("yw_stall",  32'(stall),  32'd0);
        chk("yw_fwd_d2", 32'(fwd_d2), 32'd1);
        chk("yw_fwd_d1", 32'(fwd_d1), 32'd0);
        idle(3);

        // Mult/div: mult, one independent cycle, then mfhi waits out the counter.
        step(); drive(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b1, 1'b0); #1;
        chk("md_issue_stall", 32'(stall),   32'd0);
        chk("md_issue_busy",  32'(md_busy), 32'd0);
        step(); nop(); #1;
        chk("md_busy_after", 32'(md_busy), 32'd1);
        for (int i = 0; i < int'(MD_LAT) - 1; i++) begin
            step(); drive(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd2, 2'd0, 1'b0, 1'b1); #1;
            chk("md_stall", 32'(stall), 32'd1);
        end
        step(); #1;
        chk("md_release",  32'(stall),   32'd0);
        chk("md_busy_end", 32'(md_busy), 32'd0);
        step(); nop();

        // Flush mid-stall, with a mult still busy; fresh reset clears the stall counter.
        step(); rst = 1'b0;
        step(); rst = 1'b1; #1;
        chk("fl_scnt0", stall_cnt, 32'd0);
        step(); drive(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b1, 1'b0);
        step(); drive(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd8, 2'd2, 1'b0, 1'b0); #1;
        chk("fl_md_busy", 32'(md_busy), 32'd1);
        chk("fl_lw_stall", 32'(stall),  32'd0);
        step(); drive(1'b1, 5'd8, 2'd0, 5'd0, 2'd3, 5'd9, 2'd1, 1'b0, 1'b0);
        flush = 1'b1; #1;
        chk("fl_cur_stall", 32'(stall), 32'd1);
        chk("fl_cur_eclr",  32'(eclr),  32'd1);
        step(); flush = 1'b0; #1;
        chk("fl_stall",   32'(stall),   32'd0);
        chk("fl_fwd_d1",  32'(fwd_d1),  32'd0);
        chk("fl_fwd_d2",  32'(fwd_d2),  32'd0);
        chk("fl_fwd_e1",  32'(fwd_e1),  32'd0);
        chk("fl_fwd_e2",  32'(fwd_e2),  32'd0);
        chk("fl_md_busy0", 32'(md_busy), 32'd0);
`ifdef HAZ_PERF_EN
        chk("fl_scnt", stall_cnt, 32'd1);
`else
        chk("fl_scnt", stall_cnt, 32'd0);
`endif
        step(); nop();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
